seven_segment_scan_decoder: RTL and testbench
=============================================

# seven_segment_scan_decoder

Receive-side counterpart of the BCD-to-7-segment display driver. It watches a time-multiplexed 7-segment display bus (segment lines A–G plus one-hot digit enables) and recovers the BCD value of every digit. It waits for each digit's strobe to settle and assembles a complete frame once every digit has been captured. Used as a scoreboard/monitor front end and for loop-back checking of display drivers.

## Interface
- N_DIGITS, 4, number of multiplexed digits (≥1)
- STABLE_CYCLES, 4, consecutive cycles a digit value must sit in the sample register before capture (≥1)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- A, B, C, D, E, F, G  in  1 each  segment lines, active-high
- AN  in  N_DIGITS  digit enables, active-high, one-hot when driven
- bcd_out  out  4*N_DIGITS  frame result; digit k (AN[k]) in bcd_out[4k+3:4k]
- frame_valid  out  1  one-cycle pulse: bcd_out/err_out hold a new frame
- err_out  out  1  frame contained an invalid pattern or a non-one-hot AN

## Operation
- Sample register: {AN, A..G} registered every edge; all decisions use the registered copy.
- Settle counter, width $clog2(STABLE_CYCLES+1):
  - clears when the sample differs from the previous sample, or when AN is not one-hot;
  - otherwise increments, saturating.
- FSM per dwell, states WAIT → SETTLE → CAPTURED:
  - WAIT: AN not one-hot (zero or multi-hot).
  - SETTLE: one-hot AN, counter below threshold.
  - CAPTURED: digit taken. Stays CAPTURED until the sample changes. At most one capture per dwell.
  - Any sample change returns to SETTLE (one-hot) or WAIT.
- Capture occurs when the identical one-hot sample has been present for STABLE_CYCLES cycles.
- Decode, with A..G written MSB..LSB. Only these patterns are valid:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Any other pattern, including blank 0000000, stores 4'hF and sets the frame error flag.
- Multi-hot AN: on the edge it first appears in the sample register, the frame error flag is set. No capture. All-zero AN is idle, not an error.
- Seen mask [N_DIGITS-1:0]:
  - A capture sets bit k.
  - Recapturing an already-seen digit overwrites its stored nibble; the mask is unchanged.
- Frame completion: on the capture edge that makes the mask all-ones (the capture value included):
  - bcd_out loads all stored nibbles;
  - err_out loads the frame error flag (this capture included);
  - frame_valid is high for the following cycle only;
  - mask and frame error flag clear.
- bcd_out and err_out hold between frames.

## Timing
- Reset values (asynchronous): bcd_out=0, frame_valid=0, err_out=0. Sample register, digit registers, mask, error flag and counter are 0; FSM is in WAIT.
- Latency:
  - Inputs held constant from clock edge e1 are captured on edge e(STABLE_CYCLES+1).
  - With the default STABLE_CYCLES=4, that is the 5th edge.
  - If this completes a frame, frame_valid is high in the cycle after that edge.
- Minimum dwell for capture is STABLE_CYCLES+1 edges. A dwell of STABLE_CYCLES edges or fewer is ignored.
- A change on the same edge as the would-be capture cancels the capture (the counter clears first).
- Reset asserted mid-frame discards partial captures. After release, every digit must be captured again before a frame is produced.
- N_DIGITS=1: every capture completes a frame.

## Test plan
- Reset: assert rst asynchronously mid-cycle → all outputs 0 immediately; no frame_valid for 10 cycles with AN=0.
- Normal scan (N=4, S=4): AN=0001/0010/0100/1000 carrying patterns for 1,2,3,4, each held 8 cycles → exactly one frame_valid pulse, 1 cycle wide, on the cycle after the AN=1000 capture edge (5th edge of that dwell); bcd_out=16'h4321, err_out=0.
- Glitch rejection: digit 2 held only 4 edges, then AN=0 → no capture and no frame. Then hold digit 2 with 7 (1110000) for 5 edges → captured, frame completes with nibble 2 = 7.
- Invalid pattern: digit 2 shows 0000001, others valid (1,2,_,4) → bcd_out=16'h4F21, err_out=1. Next clean frame → err_out=0.
- Multi-hot AN: AN=0011 for 10 cycles inside a frame, followed by valid captures of all digits → no capture during AN=0011; frame completes with err_out=1.
- Reset mid-frame: capture digits 0 and 1, pulse rst, then capture only digits 2 and 3 → no frame_valid. After digits 0 and 1 are recaptured → frame_valid.

Source files
------------

// File: rtl/seven_segment_scan_decoder.sv
// Monitors a multiplexed 7-segment bus and recovers one BCD nibble per digit.
// A frame is emitted once every digit has been captured after settling.
module seven_segment_scan_decoder #(
    parameter int unsigned N_DIGITS      = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  A,
    input  logic                  B,
    input  logic                  C,
    input  logic                  D,
    input  logic                  E,
    input  logic                  F,
    input  logic                  G,
    input  logic [N_DIGITS-1:0]   AN,
    output logic [4*N_DIGITS-1:0] bcd_out,
    output logic                  frame_valid,
    output logic                  err_out
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned SampW = N_DIGITS + 7;
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        StWait,
        StSettle,
        StCaptured
    } state_e;

    state_e                state_q, state_d;
    logic [SampW-1:0]      samp_q;
    logic [SampW-1:0]      samp_in;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [N_DIGITS-1:0]   mask_q, mask_d;
    logic                  err_q, err_d;
    logic [4*N_DIGITS-1:0] dig_q, dig_d;
    logic [4*N_DIGITS-1:0] bcd_d;
    logic                  err_out_d;
    logic                  frame_d;

    logic [N_DIGITS-1:0]   in_an;
    logic [N_DIGITS-1:0]   an_q;
    logic                  in_onehot;
    logic                  in_multi;
    logic                  changed;
    logic                  capture;
    logic [3:0]            nib;
    logic                  seg_bad;
    logic [N_DIGITS-1:0]   mask_new;
    logic                  err_new;

    function automatic logic [3:0] decode(input logic [6:0] seg);
        logic [3:0] v;
        case (seg)
            7'b1111110: v = 4'd0;
            7'b0110000: v = 4'd1;
            7'b1101101: v = 4'd2;
            7'b1111001: v = 4'd3;
            7'b0110011: v = 4'd4;
            7'b1011011: v = 4'd5;
            7'b1011111: v = 4'd6;
            7'b1110000: v = 4'd7;
            7'b1111111: v = 4'd8;
            7'b1111011: v = 4'd9;
            default:    v = 4'hF;
        endcase
        return v;
    endfunction

    assign samp_in = {AN, A, B, C, D, E, F, G};
    assign in_an   = AN;
    assign an_q    = samp_q[SampW-1:7];

    always_comb begin
        in_onehot = (in_an != '0) && ((in_an & (in_an - 1'b1)) == '0);
        in_multi  = (in_an != '0) && !in_onehot;
        changed   = (samp_in != samp_q);

        cnt_d = cnt_q;
        if (changed || !in_onehot) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
        end

        // The incoming sample must match the registered one, so a change on the
        // would-be capture edge cancels it.
        capture = in_onehot && !changed && (state_q == StSettle) && (cnt_d == CntMax);

        nib     = decode(samp_q[6:0]);
        seg_bad = (nib == 4'hF);

        dig_d = dig_q;
        if (capture) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                if (an_q[k]) begin
                    dig_d[4*k +: 4] = nib;
                end
            end
        end

        mask_new = capture ? (mask_q | an_q) : mask_q;
        err_new  = err_q | (capture && seg_bad) | (in_multi && changed);

        mask_d    = mask_new;
        err_d     = err_new;
        bcd_d     = bcd_out;
        err_out_d = err_out;
        frame_d   = 1'b0;
        if (capture && (&mask_new)) begin
            bcd_d     = dig_d;
            err_out_d = err_new;
            frame_d   = 1'b1;
            mask_d    = '0;
            err_d     = 1'b0;
        end

        if (!in_onehot) begin
            state_d = StWait;
        end else if (changed) begin
            state_d = StSettle;
        end else if (capture) begin
            state_d = StCaptured;
        end else begin
            state_d = state_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StWait;
            samp_q      <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            err_q       <= 1'b0;
            dig_q       <= '0;
            bcd_out     <= '0;
            err_out     <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_q      <= samp_in;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            err_q       <= err_d;
            dig_q       <= dig_d;
            bcd_out     <= bcd_d;
            err_out     <= err_out_d;
            frame_valid <= frame_d;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed bench: expected frames are queued as each frame's stimulus is driven
// and checked when frame_valid pulses.
module tb_seven_segment_scan_decoder;

    logic        clk;
    logic        rst;
    logic        A, B, C, D, E, F, G;
    logic [3:0]  AN;
    logic [15:0] bcd_out;
    logic        frame_valid;
    logic        err_out;

    int vectors;
    int miscompares;
    int frames_seen;
    logic [16:0] exp_q[$];

    seven_segment_scan_decoder #(
        .N_DIGITS     (4),
        .STABLE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .E          (E),
        .F          (F),
        .G          (G),
        .AN         (AN),
        .bcd_out    (bcd_out),
        .frame_valid(frame_valid),
        .err_out    (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic dwell(input logic [3:0] an, input logic [6:0] s, input int n);
        AN = an;
        {A, B, C, D, E, F, G} = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every pulse must match the oldest queued frame.
    always @(negedge clk) begin
        if (frame_valid) begin
            logic [16:0] e;
            frames_seen++;
            vectors++;
            assert (exp_q.size() > 0) else begin
                miscompares++;
                $error("FAIL unexpected_frame: observed bcd %0h err %0b expected none",
                       bcd_out, err_out);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("frame_bcd", 32'(bcd_out), 32'(e[15:0]));
                check("frame_err", 32'(err_out), 32'(e[16]));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        frames_seen = 0;
        rst = 1'b1;
        AN  = 4'b0;
        {A, B, C, D, E, F, G} = 7'b0;
        #12;
        check("reset_bcd", 32'(bcd_out), 32'h0);
        check("reset_fv", 32'(frame_valid), 32'h0);
        check("reset_err", 32'(err_out), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Normal scan, with exact pulse timing on the completing dwell.
        dwell(4'b0001, seg(1), 8);
        dwell(4'b0010, seg(2), 8);
        dwell(4'b0100, seg(3), 8);
        exp_q.push_back({1'b0, 16'h4321});
        AN = 4'b1000;
        {A, B, C, D, E, F, G} = seg(4);
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("scan_fv_edge%0d", e), 32'(frame_valid), 32'(e == 5));
        end
        check("scan_frames", 32'(frames_seen), 32'd1);

        // Asynchronous reset mid-cycle, then idle bus.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_bcd", 32'(bcd_out), 32'h0);
        check("async_rst_err", 32'(err_out), 32'h0);
        check("async_rst_fv", 32'(frame_valid), 32'h0);
        AN = 4'b0;
        #3 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_no_fv", 32'(frame_valid), 32'h0);
        end
        @(posedge clk);
        #1;

        // Glitch rejection: digit 2 held exactly STABLE_CYCLES edges is ignored.
        dwell(4'b0001, seg(5), 6);
        dwell(4'b0010, seg(6), 6);
        dwell(4'b1000, seg(9), 6);
        dwell(4'b0100, seg(5), 4);
        dwell(4'b0000, 7'b0, 6);
        check("glitch_no_frame", 32'(frames_seen), 32'd1);
        exp_q.push_back({1'b0, 16'h9765});
        dwell(4'b0100, seg(7), 5);
        dwell(4'b0000, 7'b0, 4);
        check("glitch_frames", 32'(frames_seen), 32'd2);

        // Invalid segment pattern on digit 2, then a clean frame.
        exp_q.push_back({1'b1, 16'h4F21});
        dwell(4'b0001, seg(1), 6);
        dwell(4'b0010, seg(2), 6);
        dwell(4'b0100, 7'b0000001, 6);
        dwell(4'b1000, seg(4), 6);
        exp_q.push_back({1'b0, 16'h3608});
        dwell(4'b0001, seg(8), 6);
        dwell(4'b0010, seg(0), 6);
        dwell(4'b0100, seg(6), 6);
        dwell(4'b1000, seg(3), 6);
        dwell(4'b0000, 7'b0, 3);
        check("invalid_frames", 32'(frames_seen), 32'd4);

        // Multi-hot AN inside a frame flags an error but captures nothing.
        exp_q.push_back({1'b1, 16'h2109});
        dwell(4'b0001, seg(5), 6);
        dwell(4'b0011, seg(8), 10);
        dwell(4'b0000, 7'b0, 3);
        dwell(4'b0001, seg(9), 6);
        dwell(4'b0010, seg(0), 6);
        dwell(4'b0100, seg(1), 6);
        dwell(4'b1000, seg(2), 6);
        dwell(4'b0000, 7'b0, 3);
        check("multihot_frames", 32'(frames_seen), 32'd5);

        // Reset mid-frame discards the partial mask.
        dwell(4'b0001, seg(3), 6);
        dwell(4'b0010, seg(4), 6);
        dwell(4'b0000, 7'b0, 2);
        #2 rst = 1'b1;
        #5 rst = 1'b0;
        @(posedge clk);
        #1;
        dwell(4'b0100, seg(5), 6);
        dwell(4'b1000, seg(6), 6);
        dwell(4'b0000, 7'b0, 10);
        check("rst_partial_no_frame", 32'(frames_seen), 32'd5);
        exp_q.push_back({1'b0, 16'h6587});
        dwell(4'b0001, seg(7), 6);
        dwell(4'b0010, seg(8), 6);
        dwell(4'b0000, 7'b0, 4);
        check("rst_recapture_frames", 32'(frames_seen), 32'd6);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
